// File: rtl/mem_pkg.sv
// mem_pkg: shared types and helpers for the parametrised dual-port data memory.
//   mem_init_e   clear-sequencer states (IDLE, CLEAR)
//   RDW_*        read-during-write mode selectors
//   clog2_bytes  byte-offset width of a word of the given bit width
package mem_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } mem_init_e;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    function automatic int clog2_bytes(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_dp_param_bank.sv
// mem_bank_dp: bare two-port byte-enable RAM array, registered read-first
// outputs on both ports, no reset on the array or the read registers.
//   clk_i                      clock
//   a_addr_i / b_addr_i        word index
//   a_we_i   / b_we_i          per-byte write enables
//   a_wdata_i / b_wdata_i      write data
//   a_rdata_o / b_rdata_o      word at the address sampled on the previous edge,
//                              before that edge's writes
// When both ports write the same byte, port A is applied last and wins.
module mem_bank_dp
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14
) (
    input  logic                  clk_i,
    input  logic [ADDR_W-1:0]     a_addr_i,
    input  logic [DATA_W/8-1:0]   a_we_i,
    input  logic [DATA_W-1:0]     a_wdata_i,
    output logic [DATA_W-1:0]     a_rdata_o,
    input  logic [ADDR_W-1:0]     b_addr_i,
    input  logic [DATA_W/8-1:0]   b_we_i,
    input  logic [DATA_W-1:0]     b_wdata_i,
    output logic [DATA_W-1:0]     b_rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    always_ff @(posedge clk_i) begin
        a_rdata_q <= mem_q[a_addr_i];
        b_rdata_q <= mem_q[b_addr_i];
        for (int i = 0; i < DATA_W/8; i++) begin
            if (b_we_i[i]) mem_q[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
        end
        for (int i = 0; i < DATA_W/8; i++) begin
            if (a_we_i[i]) mem_q[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/mem_dp_param.sv
// mem_dp_param: parametrised true dual-port byte-maskable data memory with a
// hardware clear sequencer, read-during-write bypass and optional output register.
//   clk_i, reset_i            clock, asynchronous active-high reset
//   init_req_i / init_busy_o  start clear sequence / clear in progress
//   {a,b}_en_i                access enable (every accepted access returns data)
//   {a,b}_wmask_i             byte write mask, 0 = pure read
//   {a,b}_addr_i              byte address, word index taken from [ADDR_W+OFS-1:OFS]
//   {a,b}_wdata_i             write data
//   {a,b}_rdata_o/_rvalid_o   read data, held between valid pulses
//   coll_o                    both ports wrote the same word, aligned with rvalid
//
// state | meaning
// IDLE  | ports serviced
// CLEAR | counter writes INIT_VALUE to every word, ports ignored
//
// INIT_FILE names a preload image for vendor memory-initialisation flows;
// this generic model does not load it.
module mem_dp_param
    import mem_pkg::*;
#(
    parameter int                DATA_W        = 32,
    parameter int                ADDR_W        = 14,
    parameter int                OUT_REG       = 0,
    parameter int                RDW_MODE      = RDW_READ_FIRST,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0,
    parameter int                INIT_ON_RESET = 1,
    parameter string             INIT_FILE     = ""
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  init_req_i,
    output logic                  init_busy_o,
    input  logic                  a_en_i,
    input  logic [DATA_W/8-1:0]   a_wmask_i,
    input  logic [31:0]           a_addr_i,
    input  logic [DATA_W-1:0]     a_wdata_i,
    output logic [DATA_W-1:0]     a_rdata_o,
    output logic                  a_rvalid_o,
    input  logic                  b_en_i,
    input  logic [DATA_W/8-1:0]   b_wmask_i,
    input  logic [31:0]           b_addr_i,
    input  logic [DATA_W-1:0]     b_wdata_i,
    output logic [DATA_W-1:0]     b_rdata_o,
    output logic                  b_rvalid_o,
    output logic                  coll_o
);

    localparam int NB  = DATA_W / 8;
    localparam int OFS = clog2_bytes(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_WORD = '1;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] wd,
        input logic [NB-1:0]     m
    );
        logic [DATA_W-1:0] r;
        r = base;
        for (int i = 0; i < NB; i++) begin
            if (m[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        end
        return r;
    endfunction

    // ---------------- clear sequencer ----------------
    mem_init_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (init_req_i) state_d = CLEAR;
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_WORD) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic clearing;
    assign clearing    = (state_q == CLEAR);
    assign init_busy_o = clearing;

    // ---------------- port muxing into the array ----------------
    logic [ADDR_W-1:0] a_word, b_word;
    logic              a_acc, b_acc;
    logic [ADDR_W-1:0] bank_a_addr;
    logic [NB-1:0]     bank_a_we, bank_b_we;
    logic [DATA_W-1:0] bank_a_wdata;
    logic [DATA_W-1:0] a_raw, b_raw;

    assign a_word = a_addr_i[ADDR_W+OFS-1:OFS];
    assign b_word = b_addr_i[ADDR_W+OFS-1:OFS];
    assign a_acc  = a_en_i & ~clearing;
    assign b_acc  = b_en_i & ~clearing;

    // The clear counter borrows port A with a full byte mask.
    assign bank_a_addr  = clearing ? cnt_q : a_word;
    assign bank_a_we    = clearing ? {NB{1'b1}} : (a_acc ? a_wmask_i : '0);
    assign bank_a_wdata = clearing ? INIT_VALUE : a_wdata_i;
    assign bank_b_we    = b_acc ? b_wmask_i : '0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{a_addr_i[31:ADDR_W+OFS], a_addr_i[OFS-1:0],
                                b_addr_i[31:ADDR_W+OFS], b_addr_i[OFS-1:0]};

    mem_bank_dp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk_i     (clk_i),
        .a_addr_i  (bank_a_addr),
        .a_we_i    (bank_a_we),
        .a_wdata_i (bank_a_wdata),
        .a_rdata_o (a_raw),
        .b_addr_i  (b_word),
        .b_we_i    (bank_b_we),
        .b_wdata_i (b_wdata_i),
        .b_rdata_o (b_raw)
    );

    // ---------------- access pipeline, stage 1 ----------------
    // Masks are captured already gated by acceptance, so a zero mask below
    // means "no write from that port this cycle".
    logic              a_v1_q, b_v1_q;
    logic [ADDR_W-1:0] a_word1_q, b_word1_q;
    logic [NB-1:0]     a_mask1_q, b_mask1_q;
    logic [DATA_W-1:0] a_wdata1_q, b_wdata1_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            a_v1_q     <= 1'b0;
            b_v1_q     <= 1'b0;
            a_word1_q  <= '0;
            b_word1_q  <= '0;
            a_mask1_q  <= '0;
            b_mask1_q  <= '0;
            a_wdata1_q <= '0;
            b_wdata1_q <= '0;
        end else begin
            a_v1_q     <= a_acc;
            b_v1_q     <= b_acc;
            a_word1_q  <= a_word;
            b_word1_q  <= b_word;
            a_mask1_q  <= a_acc ? a_wmask_i : '0;
            b_mask1_q  <= b_acc ? b_wmask_i : '0;
            a_wdata1_q <= a_wdata_i;
            b_wdata1_q <= b_wdata_i;
        end
    end

    // Write-first view: the word as it stands after the edge, rebuilt from the
    // old word by replaying B's bytes then A's (A wins overlaps, as in the array).
    logic              same_word;
    logic [DATA_W-1:0] a_fwd, b_fwd, a_res, b_res;
    logic              coll1;

    assign same_word = (a_word1_q == b_word1_q);

    always_comb begin
        a_fwd = a_raw;
        if (same_word) a_fwd = merge_bytes(a_fwd, b_wdata1_q, b_mask1_q);
        a_fwd = merge_bytes(a_fwd, a_wdata1_q, a_mask1_q);
        b_fwd = merge_bytes(b_raw, b_wdata1_q, b_mask1_q);
        if (same_word) b_fwd = merge_bytes(b_fwd, a_wdata1_q, a_mask1_q);
    end

    assign a_res = (RDW_MODE == RDW_WRITE_FIRST) ? a_fwd : a_raw;
    assign b_res = (RDW_MODE == RDW_WRITE_FIRST) ? b_fwd : b_raw;
    assign coll1 = same_word & (|a_mask1_q) & (|b_mask1_q);

    // ---------------- output stage ----------------
    // Holds the last returned word; it is the output register when OUT_REG=1.
    logic [DATA_W-1:0] a_out_q, b_out_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            a_out_q <= '0;
            b_out_q <= '0;
        end else begin
            if (a_v1_q) a_out_q <= a_res;
            if (b_v1_q) b_out_q <= b_res;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic a_v2_q, b_v2_q, coll2_q;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                a_v2_q  <= 1'b0;
                b_v2_q  <= 1'b0;
                coll2_q <= 1'b0;
            end else begin
                a_v2_q  <= a_v1_q;
                b_v2_q  <= b_v1_q;
                coll2_q <= coll1;
            end
        end

        assign a_rvalid_o = a_v2_q;
        assign b_rvalid_o = b_v2_q;
        assign a_rdata_o  = a_out_q;
        assign b_rdata_o  = b_out_q;
        assign coll_o     = coll2_q;
    end else begin : g_out_comb
        assign a_rvalid_o = a_v1_q;
        assign b_rvalid_o = b_v1_q;
        assign a_rdata_o  = a_v1_q ? a_res : a_out_q;
        assign b_rdata_o  = b_v1_q ? b_res : b_out_q;
        assign coll_o     = coll1;
    end

endmodule

// File: tb/tb_mem_dp_param.sv
module tb_mem_dp_param;

    localparam int          DW   = 32;
    localparam int          AW   = 4;
    localparam int          NW   = 1 << AW;
    localparam logic [31:0] INIT = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_req = 1'b0;
    logic        a_en = 1'b0, b_en = 1'b0;
    logic [3:0]  a_wmask = '0, b_wmask = '0;
    logic [31:0] a_addr = '0, b_addr = '0, a_wdata = '0, b_wdata = '0;

    // u0: OUT_REG=0, read-first.  u1: OUT_REG=1, write-first.
    logic        busy0, a_rv0, b_rv0, coll0;
    logic [31:0] a_rd0, b_rd0;
    logic        busy1, a_rv1, b_rv1, coll1;
    logic [31:0] a_rd1, b_rd1;

    always #5 clk = ~clk;

    mem_dp_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .RDW_MODE(0),
                   .INIT_VALUE(INIT), .INIT_ON_RESET(1)) u0 (
        .clk_i(clk), .reset_i(rst), .init_req_i(init_req), .init_busy_o(busy0),
        .a_en_i(a_en), .a_wmask_i(a_wmask), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_rdata_o(a_rd0), .a_rvalid_o(a_rv0),
        .b_en_i(b_en), .b_wmask_i(b_wmask), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_rdata_o(b_rd0), .b_rvalid_o(b_rv0), .coll_o(coll0));

    mem_dp_param #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .RDW_MODE(1),
                   .INIT_VALUE(INIT), .INIT_ON_RESET(1)) u1 (
        .clk_i(clk), .reset_i(rst), .init_req_i(init_req), .init_busy_o(busy1),
        .a_en_i(a_en), .a_wmask_i(a_wmask), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_rdata_o(a_rd1), .a_rvalid_o(a_rv1),
        .b_en_i(b_en), .b_wmask_i(b_wmask), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_rdata_o(b_rd1), .b_rvalid_o(b_rv1), .coll_o(coll1));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Per-cycle result of the accesses accepted on one edge:
    // *0 = word before the edge, *1 = word after the edge.
    typedef struct {
        bit          av, bv, coll;
        logic [31:0] a0, a1, b0, b1;
    } rec_t;

    logic [31:0] mdl [NW];
    int          left;          // clear words still to write
    rec_t        rec_now, rec_prev;

    always @(posedge clk) begin
        rec_t r;
        bit   was_busy;
        int   wa, wb;
        r = '{default: 0};
        if (rst) begin
            left     = NW;
            rec_now  = '{default: 0};
            rec_prev = '{default: 0};
        end else begin
            was_busy = (left > 0);
            if (was_busy) begin
                mdl[NW - left] = INIT;
                left--;
            end else begin
                wa = int'(a_addr[AW+1:2]);
                wb = int'(b_addr[AW+1:2]);
                r.a0 = mdl[wa];
                r.b0 = mdl[wb];
                if (b_en) for (int k = 0; k < 4; k++)
                    if (b_wmask[k]) mdl[wb][k*8 +: 8] = b_wdata[k*8 +: 8];
                if (a_en) for (int k = 0; k < 4; k++)
                    if (a_wmask[k]) mdl[wa][k*8 +: 8] = a_wdata[k*8 +: 8];
                r.av   = a_en;
                r.bv   = b_en;
                r.a1   = mdl[wa];
                r.b1   = mdl[wb];
                r.coll = a_en && b_en && (wa == wb) && (a_wmask != 0) && (b_wmask != 0);
            end
            if (!was_busy && init_req) left = NW;
            rec_prev = rec_now;
            rec_now  = r;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] h0a = '0, h0b = '0, h1a = '0, h1b = '0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            chk("rst_busy0", {31'b0, busy0}, 32'd1);
            chk("rst_busy1", {31'b0, busy1}, 32'd1);
            chk("rst_out0", {a_rd0 | b_rd0}, 32'd0);
            chk("rst_out1", {a_rd1 | b_rd1}, 32'd0);
            chk("rst_flags", {26'b0, a_rv0, b_rv0, coll0, a_rv1, b_rv1, coll1}, 32'd0);
            h0a = '0; h0b = '0; h1a = '0; h1b = '0;
        end else begin
            chk("busy0", {31'b0, busy0}, {31'b0, left > 0});
            chk("busy1", {31'b0, busy1}, {31'b0, left > 0});
            chk("u0_a_rvalid", {31'b0, a_rv0}, {31'b0, rec_now.av});
            chk("u0_b_rvalid", {31'b0, b_rv0}, {31'b0, rec_now.bv});
            chk("u0_coll", {31'b0, coll0}, {31'b0, rec_now.coll});
            e = rec_now.av ? rec_now.a0 : h0a; chk("u0_a_rdata", a_rd0, e); h0a = e;
            e = rec_now.bv ? rec_now.b0 : h0b; chk("u0_b_rdata", b_rd0, e); h0b = e;
            chk("u1_a_rvalid", {31'b0, a_rv1}, {31'b0, rec_prev.av});
            chk("u1_b_rvalid", {31'b0, b_rv1}, {31'b0, rec_prev.bv});
            chk("u1_coll", {31'b0, coll1}, {31'b0, rec_prev.coll});
            e = rec_prev.av ? rec_prev.a1 : h1a; chk("u1_a_rdata", a_rd1, e); h1a = e;
            e = rec_prev.bv ? rec_prev.b1 : h1b; chk("u1_b_rdata", b_rd1, e); h1b = e;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drv_a(input bit en, input logic [3:0] m, input logic [31:0] ad, input logic [31:0] d);
        a_en = en; a_wmask = m; a_addr = ad; a_wdata = d;
    endtask

    task automatic drv_b(input bit en, input logic [3:0] m, input logic [31:0] ad, input logic [31:0] d);
        b_en = en; b_wmask = m; b_addr = ad; b_wdata = d;
    endtask

    task automatic idle();
        drv_a(0, 4'h0, 32'h0, 32'h0);
        drv_b(0, 4'h0, 32'h0, 32'h0);
        init_req = 1'b0;
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            cyc();
        end
        chk(nm, n, 32'd16);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        idle();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // 1. clear after reset lasts 16 cycles, every word reads INIT
        count_busy("init_len");
        for (int i = 0; i < NW + 2; i++) begin
            if (i < NW) drv_a(1, 4'h0, 32'(i * 4), 32'h0);
            else        idle();
            cyc();
            if (i < NW)              chk("t1_u0_init", a_rd0, INIT);
            if (i >= 1 && i <= NW)   chk("t1_u1_init", a_rd1, INIT);
        end

        // 2. write then read back at latency 1 / 2
        drv_a(1, 4'hF, 32'h10, 32'hDEAD_BEEF); cyc();
        drv_a(1, 4'h0, 32'h10, 32'h0);         cyc();
        chk("t2_u0_rd", a_rd0, 32'hDEAD_BEEF);
        chk("t2_u0_rv", {31'b0, a_rv0}, 32'd1);
        idle(); cyc();
        chk("t2_u1_rd", a_rd1, 32'hDEAD_BEEF);

        // 3. same-port read during partial write
        drv_a(1, 4'hF, 32'h20, 32'h1122_3344); cyc();
        drv_a(1, 4'h3, 32'h20, 32'hAAAA_AAAA); cyc();
        chk("t3_u0_rdw", a_rd0, 32'h1122_3344);
        idle(); cyc();
        chk("t3_u1_rdw", a_rd1, 32'h1122_AAAA);

        // 4. same-word collision
        drv_a(1, 4'hF, 32'h30, 32'h1122_3344); cyc();
        drv_a(1, 4'h6, 32'h30, 32'hAAAA_AAAA);
        drv_b(1, 4'hC, 32'h30, 32'hBBBB_BBBB); cyc();
        chk("t4_u0_coll", {31'b0, coll0}, 32'd1);
        chk("t4_u0_old", a_rd0, 32'h1122_3344);
        idle(); cyc();
        chk("t4_u0_coll_end", {31'b0, coll0}, 32'd0);
        chk("t4_u1_coll", {31'b0, coll1}, 32'd1);
        chk("t4_u1_merged", b_rd1, 32'hBBAA_AA44);
        drv_b(1, 4'h0, 32'h30, 32'h0); cyc();
        chk("t4_u1_coll_end", {31'b0, coll1}, 32'd0);
        chk("t4_u0_readback", b_rd0, 32'hBBAA_AA44);
        idle(); cyc();

        // 5. clear requested under streaming B reads, then reset mid-clear
        for (int i = 0; i < 3; i++) begin
            drv_b(1, 4'h0, 32'(i * 4), 32'h0); cyc();
        end
        init_req = 1'b1;
        drv_b(1, 4'h0, 32'h30, 32'h0); cyc();
        chk("t5_last_rv", {31'b0, b_rv0}, 32'd1);
        init_req = 1'b0;
        drv_a(1, 4'hF, 32'h10, 32'h1234_5678);
        drv_b(1, 4'h0, 32'h34, 32'h0); cyc();
        chk("t5_rv_drop", {31'b0, b_rv0}, 32'd0);
        chk("t5_busy", {31'b0, busy0}, 32'd1);
        repeat (4) cyc();
        rst = 1'b1;
        #1;
        chk("t5_rst_rv", {28'b0, a_rv0, b_rv0, a_rv1, b_rv1}, 32'd0);
        chk("t5_rst_rd0", b_rd0, 32'd0);
        chk("t5_rst_rd1", b_rd1, 32'd0);
        idle();
        cyc();
        rst = 1'b0;
        count_busy("reinit_len");
        drv_a(1, 4'h0, 32'h10, 32'h0); cyc();
        chk("t5_cleared", a_rd0, INIT);
        idle(); cyc();

        // 6. randomized back-to-back traffic with aliasing and collisions
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) ra[AW+1:2] = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) rb[AW+1:2] = ra[AW+1:2];
            drv_a($urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, ra, $urandom);
            drv_b($urandom_range(0, 3) != 0, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, rb, $urandom);
            init_req = ($urandom_range(0, 499) == 0);
            cyc();
        end
        idle();
        repeat (4) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
